// File: rtl/exp_bias_seq_m_pkg.sv
// Shared constants for the sequential exponent-bias operator: state encoding,
// IEEE exponent widths/biases and a bias helper.
package exp_bias_seq_m_pkg;

  localparam int unsigned W_EXP_SP = 8;
  localparam int unsigned W_EXP_DP = 11;

  localparam logic [7:0]  BIAS_SP = 8'd127;
  localparam logic [10:0] BIAS_DP = 11'd1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Exponent bias for a given exponent width: 2^(w-1) - 1.
  function automatic int unsigned bias_of(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/exp_bias_subtractor.sv
// Combinational removal of the exponent bias from the exponent sum.
// Underflow output exists only when EXP_UNDERFLOW_EN is defined.
module exp_bias_subtractor
  import exp_bias_seq_m_pkg::*;
#(
  parameter int unsigned W_Exp = W_EXP_SP
) (
  input  logic [W_Exp:0]   sum,
  output logic [W_Exp-1:0] exp_o,
  output logic             cout_exp
`ifdef EXP_UNDERFLOW_EN
  ,
  output logic             underflow
`endif
);

  localparam int unsigned DW = W_Exp + 2;
  localparam logic [DW-1:0] BIAS = DW'(bias_of(W_Exp));

  logic [DW-1:0] diff;

  // Sum is at most 2^(W+1)-2, so the top bit of diff is set only when negative.
  assign diff     = {1'b0, sum} - BIAS;
  assign exp_o    = diff[W_Exp-1:0];
  assign cout_exp = ~diff[DW-1] & diff[W_Exp];

`ifdef EXP_UNDERFLOW_EN
  assign underflow = diff[DW-1];
`endif

endmodule

// File: rtl/exp_bias_seq_m.sv
// Sequential exp_a + exp_b - bias over ADD/SUB steps with start/done/ack handshake.
// Optional underflow flag built only when EXP_UNDERFLOW_EN is defined.
module exp_bias_seq_m
  import exp_bias_seq_m_pkg::*;
#(
  parameter int unsigned W_Exp = W_EXP_SP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W_Exp-1:0] exp_a,
  input  logic [W_Exp-1:0] exp_b,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             load_o,
  output logic [W_Exp-1:0] exp_o,
  output logic             cout_exp,
  output logic             underflow
);

  state_t           state;
  logic [W_Exp-1:0] a_r;
  logic [W_Exp-1:0] b_r;
  logic [W_Exp:0]   sum_r;
  logic [W_Exp-1:0] exp_c;
  logic             cout_c;
`ifdef EXP_UNDERFLOW_EN
  logic             underflow_c;
`endif

  exp_bias_subtractor #(.W_Exp(W_Exp)) u_sub (
    .sum      (sum_r),
    .exp_o    (exp_c),
    .cout_exp (cout_c)
`ifdef EXP_UNDERFLOW_EN
    ,
    .underflow(underflow_c)
`endif
  );

  // Control FSM with capture, sum and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_o   <= 1'b0;
      exp_o    <= '0;
      cout_exp <= 1'b0;
    end else begin
      load_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= exp_a;
            b_r   <= exp_b;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sum_r <= {1'b0, a_r} + {1'b0, b_r};
          state <= SUB;
        end
        SUB: begin
          exp_o    <= exp_c;
          cout_exp <= cout_c;
          done     <= 1'b1;
          load_o   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          // ack wins over a simultaneous start; that start is dropped.
          if (ack) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXP_UNDERFLOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (state == SUB) begin
      underflow <= underflow_c;
    end
  end
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_exp_bias_seq_m.sv
// Directed scoreboard bench for exp_bias_seq_m at W_Exp=8 and W_Exp=11.
module tb_exp_bias_seq_m;

  typedef struct {
    logic [10:0] e;
    logic        c;
    logic        u;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, ack8, start11, ack11;
  logic [7:0]  a8, b8;
  logic [10:0] a11, b11;
  logic        busy8, done8, load8, cout8, uf8;
  logic        busy11, done11, load11, cout11, uf11;
  logic [7:0]  exp8;
  logic [10:0] exp11;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  exp_bias_seq_m #(.W_Exp(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .exp_a(a8), .exp_b(b8), .ack(ack8),
    .busy(busy8), .done(done8), .load_o(load8), .exp_o(exp8),
    .cout_exp(cout8), .underflow(uf8)
  );

  exp_bias_seq_m #(.W_Exp(11)) dut11 (
    .clk(clk), .rst(rst), .start(start11), .exp_a(a11), .exp_b(b11), .ack(ack11),
    .busy(busy11), .done(done11), .load_o(load11), .exp_o(exp11),
    .cout_exp(cout11), .underflow(uf11)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int w);
    exp_t r;
    int   d;
    d   = a + b - ((1 << (w - 1)) - 1);
    r.e = 11'(d & ((1 << w) - 1));
    r.c = (d >= (1 << w));
`ifdef EXP_UNDERFLOW_EN
    r.u = (d < 0);
`else
    r.u = 1'b0;
`endif
    return r;
  endfunction

  // One full transaction on the selected DUT, ack given in the first DONE cycle.
  task automatic op(input int w, input int a, input int b, input string tag);
    exp_t want;
    int   cyc;
    @(negedge clk);
    if (w == 8) begin a8 = 8'(a); b8 = 8'(b); start8 = 1'b1; end
    else begin a11 = 11'(a); b11 = 11'(b); start11 = 1'b1; end
    sb.push_back(model(a, b, w));
    @(negedge clk);
    start8 = 1'b0; start11 = 1'b0;
    a8 = '1; b8 = '1; a11 = '1; b11 = '1;
    cyc = 1;
    while (!((w == 8) ? done8 : done11) && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd3);
    chk({tag, "_load"}, 32'((w == 8) ? load8 : load11), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      want = sb.pop_front();
      chk({tag, "_exp"}, (w == 8) ? 32'(exp8) : 32'(exp11), 32'(want.e));
      chk({tag, "_cout"}, 32'((w == 8) ? cout8 : cout11), 32'(want.c));
      chk({tag, "_uf"}, 32'((w == 8) ? uf8 : uf11), 32'(want.u));
    end
    ack8 = (w == 8); ack11 = (w != 8);
    @(negedge clk);
    ack8 = 1'b0; ack11 = 1'b0;
    chk({tag, "_done_clr"}, 32'((w == 8) ? done8 : done11), 32'd0);
  endtask

  initial begin
    exp_t want;
    int   cyc, loads, dcyc;
    rst = 1'b1;
    start8 = 1'b0; ack8 = 1'b0; a8 = '0; b8 = '0;
    start11 = 1'b0; ack11 = 1'b0; a11 = '0; b11 = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs8", {busy8, done8, load8, cout8, uf8, exp8}, 32'd0);
    chk("rst_outs11", {busy11, done11, load11, cout11, uf11, exp11}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy8), 32'd0);

    op(8, 'h80, 'h81, "nominal");
    op(8, 'hFE, 'hFE, "overflow");
    op(8, 'h01, 'h02, "underflow");
    op(11, 'h3FF, 'h400, "dp");
    op(8, 'h00, 'h00, "zero");

    // start held high throughout, ack withheld for 5 DONE cycles
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h81; start8 = 1'b1;
    sb.push_back(model('h80, 'h81, 8));
    cyc = 0; loads = 0; dcyc = 0;
    while (dcyc < 5 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (load8) begin
        loads++;
        if (sb.size() != 0) begin
          want = sb.pop_front();
          chk("hs_exp", 32'(exp8), 32'(want.e));
        end
      end
      if (done8) dcyc++;
    end
    chk("hs_done_span", 32'(cyc), 32'd7);
    chk("hs_load_once", 32'(loads), 32'd1);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    chk("hs_ack_idle", {busy8, done8}, 32'd0);
    start8 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hs_no_new_op", {busy8, done8, load8}, 32'd0);
    end
    chk("hs_sb_drained", 32'(sb.size()), 32'd0);

    // reset while in SUB aborts the operation
    op(8, 'h80, 'h81, "pre_rst");
    @(negedge clk);
    a8 = 8'hFE; b8 = 8'hFE; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    chk("sub_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst", {busy8, done8, load8, cout8, uf8, exp8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", {busy8, done8, load8}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
